// File: rtl/chip8_mem_xfer.sv
// chip8_mem_xfer: FX55 / FX65 / FX33 sequencer moving bytes between the register file and RAM.
module chip8_mem_xfer #(
    parameter int INCREMENT_I = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  x,
    input  logic [11:0] i_addr,
    output logic [3:0]  reg_raddr,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [3:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic [11:0] ram_raddr,
    input  logic [7:0]  ram_rdata,
    output logic        ram_we,
    output logic [11:0] ram_waddr,
    output logic [7:0]  ram_wdata,
    output logic        busy,
    output logic        done,
    output logic        i_update,
    output logic [11:0] i_next
);
    typedef enum logic [2:0] {IDLE, STORE, LOAD, BCD, DONE} state_t;
    state_t state, state_n;
    logic        ld_st_q;
    logic [3:0]  x_q;
    logic [11:0] i_q;
    logic [4:0]  cnt;
    logic [11:0] ram_addr;
    logic        inc;
    assign inc = (INCREMENT_I != 0);
    assign ram_addr = i_q + 12'(cnt);
    // State register, per-state step counter, operand latch and the reported I
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            ld_st_q <= 1'b0;
            x_q     <= 4'd0;
            i_q     <= 12'd0;
            i_next  <= 12'd0;
        end else begin
            state <= state_n;
            cnt   <= (state != IDLE && state_n == state) ? cnt + 5'd1 : 5'd0;
            if (state == IDLE && start) begin
                ld_st_q <= !op[1];
                x_q     <= x;
                i_q     <= i_addr;
            end
            if (inc && (state == STORE || state == LOAD) && state_n == DONE)
                i_next <= i_q + 12'(x_q) + 12'd1;
        end
    end
    // Next state and port drive; strobes are squashed while reset is high so an aborted op writes nothing more
    always_comb begin
        state_n   = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        i_update  = 1'b0;
        reg_raddr = 4'd0;
        reg_we    = 1'b0;
        reg_waddr = 4'd0;
        reg_wdata = 8'd0;
        ram_raddr = 12'd0;
        ram_we    = 1'b0;
        ram_waddr = 12'd0;
        ram_wdata = 8'd0;
        case (state)
            IDLE: begin
                if (start)
                    state_n = (op == 2'b00) ? STORE : (op == 2'b01) ? LOAD : (op == 2'b10) ? BCD : DONE;
            end
            STORE: begin
                reg_raddr = cnt[3:0];
                ram_we    = !reset;
                ram_waddr = ram_addr;
                ram_wdata = reg_rdata;
                state_n   = (cnt[3:0] == x_q) ? DONE : STORE;
            end
            LOAD: begin
                ram_raddr = ram_addr;
                reg_we    = (cnt != 5'd0) && !reset;
                reg_waddr = cnt[3:0] - 4'd1;
                reg_wdata = ram_rdata;
                state_n   = (cnt == {1'b0, x_q} + 5'd1) ? DONE : LOAD;
            end
            BCD: begin
                reg_raddr = x_q;
                ram_we    = !reset;
                ram_waddr = ram_addr;
                ram_wdata = (cnt == 5'd0) ? reg_rdata / 8'd100 : (cnt == 5'd1) ? (reg_rdata / 8'd10) % 8'd10 : reg_rdata % 8'd10;
                state_n   = (cnt == 5'd2) ? DONE : BCD;
            end
            DONE: begin
                done     = !reset;
                i_update = inc && ld_st_q && !reset;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_chip8_mem_xfer.sv
// tb_chip8_mem_xfer: randomized and directed checks of chip8_mem_xfer against a cycle-table reference model.
module tb_chip8_mem_xfer;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] op = 2'd0;
    logic [3:0] x = 4'd0;
    logic [11:0] i_addr = 12'd0;
    logic [3:0] reg_raddr, reg_waddr, reg_raddr0, reg_waddr0;
    logic [7:0] reg_rdata, reg_wdata, reg_wdata0, ram_rdata, ram_wdata, ram_wdata0;
    logic [11:0] ram_raddr, ram_waddr, i_next, ram_raddr0, ram_waddr0, i_next0;
    logic reg_we, ram_we, busy, done, i_update, reg_we0, ram_we0, busy0, done0, i_update0;
    always #5 clk = ~clk;

    chip8_mem_xfer #(.INCREMENT_I(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .i_addr(i_addr),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .i_update(i_update), .i_next(i_next));

    chip8_mem_xfer #(.INCREMENT_I(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .i_addr(i_addr),
        .reg_raddr(reg_raddr0), .reg_rdata(reg_rdata), .reg_we(reg_we0), .reg_waddr(reg_waddr0), .reg_wdata(reg_wdata0),
        .ram_raddr(ram_raddr0), .ram_rdata(ram_rdata), .ram_we(ram_we0), .ram_waddr(ram_waddr0), .ram_wdata(ram_wdata0),
        .busy(busy0), .done(done0), .i_update(i_update0), .i_next(i_next0));

    logic [7:0] mem [4096];
    logic [7:0] rf [16];
    logic [7:0] m_mem [4096];
    logic [7:0] m_rf [16];
    assign reg_rdata = rf[reg_raddr];
    always @(posedge clk) ram_rdata <= mem[ram_raddr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] = ram_wdata;
        if (reg_we) rf[reg_waddr] = reg_wdata;
    end

    int checks = 0, errors = 0;
    int e_busy[64], e_done[64], e_iupd[64], e_ram_we[64], e_ram_addr[64], e_ram_data[64];
    int e_rd[64], e_rd_addr[64], e_reg_we[64], e_reg_addr[64], e_reg_data[64];
    int e_inext, m_inext = 0, last = 0, cyc = 0;
    bit act = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit live(input int c, input int rc);
        return rc == 0 || c < rc;
    endfunction

    // Expected per-cycle behaviour of one operation, derived from the operation rules
    task automatic build(input int o, input int xx, input int ii, input int rc);
        int d, v, dig[3];
        for (int c = 0; c < 64; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_iupd[c] = 0; e_ram_we[c] = 0; e_ram_addr[c] = 0; e_ram_data[c] = 0;
            e_rd[c] = 0; e_rd_addr[c] = 0; e_reg_we[c] = 0; e_reg_addr[c] = 0; e_reg_data[c] = 0;
        end
        d = (o == 0) ? xx + 2 : (o == 1) ? xx + 3 : (o == 2) ? 4 : 1;
        if (o == 0)
            for (int k = 0; k <= xx; k++)
                if (live(k + 1, rc)) begin
                    e_ram_we[k + 1] = 1; e_ram_addr[k + 1] = (ii + k) % 4096; e_ram_data[k + 1] = m_rf[k];
                    m_mem[(ii + k) % 4096] = m_rf[k];
                end
        if (o == 1)
            for (int k = 0; k <= xx; k++) begin
                if (live(k + 1, rc)) begin
                    e_rd[k + 1] = 1; e_rd_addr[k + 1] = (ii + k) % 4096;
                end
                if (live(k + 2, rc)) begin
                    e_reg_we[k + 2] = 1; e_reg_addr[k + 2] = k; e_reg_data[k + 2] = m_mem[(ii + k) % 4096];
                    m_rf[k] = m_mem[(ii + k) % 4096];
                end
            end
        if (o == 2) begin
            v = m_rf[xx];
            dig[0] = v / 100; dig[1] = (v / 10) % 10; dig[2] = v % 10;
            for (int k = 0; k < 3; k++)
                if (live(k + 1, rc)) begin
                    e_ram_we[k + 1] = 1; e_ram_addr[k + 1] = (ii + k) % 4096; e_ram_data[k + 1] = dig[k];
                    m_mem[(ii + k) % 4096] = 8'(dig[k]);
                end
        end
        for (int c = 1; c <= d; c++) e_busy[c] = live(c, rc) ? 1 : 0;
        if (live(d, rc)) begin
            e_done[d] = 1;
            e_iupd[d] = (o < 2) ? 1 : 0;
            e_inext = (ii + xx + 1) % 4096;
        end
        last = (rc > 0) ? rc + 1 : d + 1;
    endtask

    // Single compare process: DUT outputs against the expected table every cycle of an operation
    always @(negedge clk) if (act) begin
        cyc++;
        if (e_iupd[cyc] != 0) m_inext = e_inext;
        if (!reset) begin
            chk("busy", busy, e_busy[cyc]);
            chk("busy_p0", busy0, e_busy[cyc]);
        end
        chk("done", done, e_done[cyc]);
        chk("i_update", i_update, e_iupd[cyc]);
        chk("ram_we", ram_we, e_ram_we[cyc]);
        chk("reg_we", reg_we, e_reg_we[cyc]);
        if (e_ram_we[cyc] != 0) begin
            chk("ram_waddr", ram_waddr, e_ram_addr[cyc]);
            chk("ram_wdata", ram_wdata, e_ram_data[cyc]);
        end
        if (e_rd[cyc] != 0) chk("ram_raddr", ram_raddr, e_rd_addr[cyc]);
        if (e_reg_we[cyc] != 0) begin
            chk("reg_waddr", reg_waddr, e_reg_addr[cyc]);
            chk("reg_wdata", reg_wdata, e_reg_data[cyc]);
        end
        chk("i_next", i_next, m_inext);
        chk("done_p0", done0, e_done[cyc]);
        chk("i_update_p0", i_update0, 0);
        chk("ram_we_p0", ram_we0, e_ram_we[cyc]);
        chk("reg_we_p0", reg_we0, e_reg_we[cyc]);
        chk("i_next_p0", i_next0, 0);
        if (cyc >= last) act = 0;
    end

    task automatic poke_ram(input int a, input logic [7:0] d);
        mem[a] = d; m_mem[a] = d;
    endtask

    task automatic poke_reg(input int r, input logic [7:0] d);
        rf[r] = d; m_rf[r] = d;
    endtask

    task automatic run(input int o, input int xx, input int ii, input int rc, input int rsc);
        int n, bad;
        @(negedge clk);
        build(o, xx, ii, rc);
        op = 2'(o); x = 4'(xx); i_addr = 12'(ii); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); x = 4'($urandom); i_addr = 12'($urandom);
        cyc = 0; act = 1; n = 1;
        while (act && n < 60) begin
            if (n == rc) reset = 1'b1;
            if (rc > 0 && n == rc + 1) begin
                reset = 1'b0;
                m_inext = 0;
            end
            start = (n == rsc);
            if (n == rsc) op = 2'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        if (act) begin
            checks++; errors++; act = 0; reset = 1'b0; start = 1'b0;
            $display("FAIL timeout op=%0d x=%0d: operation never ended", o, xx);
        end
        bad = 0;
        for (int a = 0; a < 4096; a++) if (mem[a] !== m_mem[a]) bad++;
        for (int r = 0; r < 16; r++) if (rf[r] !== m_rf[r]) bad++;
        chk("mem_image_mismatches", bad, 0);
    endtask

    initial begin
        int o, xx, d, rc, rsc;
        for (int a = 0; a < 4096; a++) poke_ram(a, 8'($urandom));
        for (int r = 0; r < 16; r++) poke_reg(r, 8'($urandom));
        start = 1'b1; x = 4'd3; i_addr = 12'h123;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_i_update", i_update, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_i_next", i_next, 12'h000);
        chk("rst_ram_waddr", ram_waddr, 0);
        chk("rst_ram_raddr", ram_raddr, 0);
        chk("rst_reg_raddr", reg_raddr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_busy_p0", busy0, 0);
        poke_reg(0, 8'd11); poke_reg(1, 8'd22); poke_reg(2, 8'd33); poke_reg(3, 8'd44);
        poke_ram('h304, 8'h5A);
        run(0, 3, 'h300, 0, 0);
        chk("st_mem300", mem['h300], 8'd11);
        chk("st_mem301", mem['h301], 8'd22);
        chk("st_mem302", mem['h302], 8'd33);
        chk("st_mem303", mem['h303], 8'd44);
        chk("st_mem304", mem['h304], 8'h5A);
        chk("st_i_next", i_next, 12'h304);
        poke_ram('hFFE, 8'hAA); poke_ram('hFFF, 8'hBB); poke_ram('h000, 8'hCC);
        run(1, 2, 'hFFE, 0, 0);
        chk("ld_v0", rf[0], 8'hAA);
        chk("ld_v1", rf[1], 8'hBB);
        chk("ld_v2", rf[2], 8'hCC);
        chk("ld_i_next", i_next, 12'h001);
        poke_reg(5, 8'hFE);
        run(2, 5, 'h400, 0, 0);
        chk("bcd_hund", mem['h400], 8'd2);
        chk("bcd_tens", mem['h401], 8'd5);
        chk("bcd_ones", mem['h402], 8'd4);
        chk("bcd_i_next", i_next, 12'h001);
        poke_reg(6, 8'h07);
        run(2, 6, 'h410, 0, 0);
        chk("bcd7_hund", mem['h410], 8'd0);
        chk("bcd7_tens", mem['h411], 8'd0);
        chk("bcd7_ones", mem['h412], 8'd7);
        run(0, 4, 'h500, 0, 2);
        run(3, 9, 'h600, 0, 0);
        chk("rsv_i_next", i_next, 12'h505);
        run(0, 0, 'h650, 0, 0);
        chk("noinc_i_next_p0", i_next0, 12'h000);
        chk("inc_i_next", i_next, 12'h651);
        poke_ram('h702, 8'h77);
        run(0, 15, 'h700, 3, 0);
        chk("abort_mem700", mem['h700], 8'hAA);
        chk("abort_mem701", mem['h701], 8'hBB);
        chk("abort_mem702", mem['h702], 8'h77);
        chk("abort_i_next", i_next, 12'h000);
        for (int t = 0; t < 40; t++) begin
            o = $urandom_range(0, 3);
            xx = $urandom_range(0, 15);
            d = (o == 0) ? xx + 2 : (o == 1) ? xx + 3 : (o == 2) ? 4 : 1;
            rc = ($urandom_range(0, 5) == 0 && d > 1) ? $urandom_range(1, d - 1) : 0;
            rsc = (rc == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, d) : 0;
            run(o, xx, $urandom_range(0, 4095), rc, rsc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
